// File: rtl/wb_timeout_bridge_if.sv
// Classic WISHBONE bus bundle; one instance per side of the bridge.
interface wb_timeout_bridge_if #(
  parameter int AW = 16,
  parameter int DW = 32
) ();
  logic            cyc;
  logic            stb;
  logic            we;
  logic [AW-1:0]   adr;
  logic [DW-1:0]   dat_w;
  logic [DW/8-1:0] sel;
  logic [DW-1:0]   dat_r;
  logic            ack;
  logic            err;

  modport master (
    output cyc, stb, we, adr, dat_w, sel,
    input  dat_r, ack, err
  );

  modport slave (
    input  cyc, stb, we, adr, dat_w, sel,
    output dat_r, ack, err
  );
endinterface

// File: rtl/wb_timeout_bridge.sv
// Single-outstanding WISHBONE bridge: registers each host request, forwards it to the
// target and terminates it with err if the target stays silent for TIMEOUT_CYCLES.
module wb_timeout_bridge #(
  parameter int ADDRESS_WIDTH  = 16,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TCOUNT_WIDTH   = 8
) (
  input  logic                    clk_i,
  input  logic                    rst_n_i,
  wb_timeout_bridge_if.slave      s_wb,
  wb_timeout_bridge_if.master     m_wb,
  output logic                    timeout_o,
  output logic [TCOUNT_WIDTH-1:0] timeout_count_o
);

  localparam int SW = DATA_WIDTH / 8;
  localparam int WW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [WW-1:0] LAST_WAIT = WW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t                   r_state;
  logic [WW-1:0]            r_wait;
  logic                     r_cyc;
  logic                     r_we;
  logic [ADDRESS_WIDTH-1:0] r_adr;
  logic [DATA_WIDTH-1:0]    r_wdat;
  logic [SW-1:0]            r_sel;
  logic [DATA_WIDTH-1:0]    r_rdat;
  logic                     r_ack;
  logic                     r_err;
  logic                     r_timeout;
  logic [TCOUNT_WIDTH-1:0]  r_tcount;

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_cyc     <= 1'b0;
      r_we      <= 1'b0;
      r_adr     <= '0;
      r_wdat    <= '0;
      r_sel     <= '0;
      r_rdat    <= '0;
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_tcount  <= '0;
    end else begin
      // Host response and timeout flags are single-cycle pulses; read data clears with them.
      r_ack     <= 1'b0;
      r_err     <= 1'b0;
      r_timeout <= 1'b0;
      r_rdat    <= '0;
      case (r_state)
        IDLE: begin
          if (s_wb.cyc && s_wb.stb) begin
            r_we    <= s_wb.we;
            r_adr   <= s_wb.adr;
            r_wdat  <= s_wb.dat_w;
            r_sel   <= s_wb.sel;
            r_wait  <= '0;
            r_cyc   <= 1'b1;
            r_state <= REQ;
          end
        end
        REQ: begin
          if (!s_wb.cyc) begin
            r_cyc   <= 1'b0;
            r_state <= IDLE;
          end else if (m_wb.err) begin
            r_cyc   <= 1'b0;
            r_err   <= 1'b1;
            r_state <= RESP;
          end else if (m_wb.ack) begin
            r_cyc   <= 1'b0;
            r_ack   <= 1'b1;
            r_rdat  <= r_we ? '0 : m_wb.dat_r;
            r_state <= RESP;
          end else if (r_wait == LAST_WAIT) begin
            r_cyc     <= 1'b0;
            r_err     <= 1'b1;
            r_timeout <= 1'b1;
            if (r_tcount != '1)
              r_tcount <= r_tcount + TCOUNT_WIDTH'(1);
            r_state   <= RESP;
          end else begin
            r_wait <= r_wait + WW'(1);
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign m_wb.cyc   = r_cyc;
  assign m_wb.stb   = r_cyc;
  assign m_wb.we    = r_we;
  assign m_wb.adr   = r_adr;
  assign m_wb.dat_w = r_wdat;
  assign m_wb.sel   = r_sel;

  assign s_wb.dat_r = r_rdat;
  assign s_wb.ack   = r_ack;
  assign s_wb.err   = r_err;

  assign timeout_o       = r_timeout;
  assign timeout_count_o = r_tcount;

endmodule

// File: tb/tb_wb_timeout_bridge.sv
// Directed bench for wb_timeout_bridge with TIMEOUT_CYCLES=8 and an 8-bit timeout counter.
module tb_wb_timeout_bridge;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       timeout;
  logic [7:0] tcount;
  int         n_cmp = 0;
  int         n_fail = 0;

  wb_timeout_bridge_if #(.AW(16), .DW(32)) s_if ();
  wb_timeout_bridge_if #(.AW(16), .DW(32)) m_if ();

  wb_timeout_bridge #(
    .ADDRESS_WIDTH (16),
    .DATA_WIDTH    (32),
    .TIMEOUT_CYCLES(8),
    .TCOUNT_WIDTH  (8)
  ) dut (
    .clk_i          (clk),
    .rst_n_i        (rst_n),
    .s_wb           (s_if.slave),
    .m_wb           (m_if.master),
    .timeout_o      (timeout),
    .timeout_count_o(tcount)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic host_req(input logic we, input logic [15:0] adr,
                          input logic [31:0] dat, input logic [3:0] sel);
    s_if.cyc   = 1'b1;
    s_if.stb   = 1'b1;
    s_if.we    = we;
    s_if.adr   = adr;
    s_if.dat_w = dat;
    s_if.sel   = sel;
  endtask

  task automatic host_drop();
    s_if.cyc = 1'b0;
    s_if.stb = 1'b0;
  endtask

  initial begin
    s_if.cyc = 1'b0; s_if.stb = 1'b0; s_if.we = 1'b0;
    s_if.adr = '0; s_if.dat_w = '0; s_if.sel = '0;
    m_if.dat_r = '0; m_if.ack = 1'b0; m_if.err = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_m_cyc", m_if.cyc, 0);
    chk("rst_m_stb", m_if.stb, 0);
    chk("rst_s_ack", s_if.ack, 0);
    chk("rst_s_err", s_if.err, 0);
    chk("rst_s_dat", s_if.dat_r, 0);
    chk("rst_tmo", timeout, 0);
    chk("rst_tcnt", tcount, 0);
    rst_n = 1'b1;
    tick();

    // 1: write, target acks on third strobe cycle
    host_req(1'b1, 16'h1234, 32'hCAFEF00D, 4'hF);
    tick();
    chk("t1_m_cyc", m_if.cyc, 1);
    chk("t1_m_stb", m_if.stb, 1);
    chk("t1_m_we", m_if.we, 1);
    chk("t1_m_adr", m_if.adr, 16'h1234);
    chk("t1_m_dat", m_if.dat_w, 32'hCAFEF00D);
    chk("t1_m_sel", m_if.sel, 4'hF);
    chk("t1_ack_early0", s_if.ack, 0);
    tick();
    chk("t1_ack_early1", s_if.ack, 0);
    chk("t1_stb_hold", m_if.stb, 1);
    tick();
    chk("t1_ack_early2", s_if.ack, 0);
    m_if.ack = 1'b1;
    tick();
    m_if.ack = 1'b0;
    chk("t1_ack", s_if.ack, 1);
    chk("t1_err", s_if.err, 0);
    chk("t1_m_cyc_off", m_if.cyc, 0);
    chk("t1_wr_dat", s_if.dat_r, 0);
    host_drop();
    tick();
    chk("t1_ack_once", s_if.ack, 0);
    chk("t1_err_after", s_if.err, 0);
    tick();

    // 2: read to a silent target times out
    host_req(1'b0, 16'h0040, 32'h0, 4'hF);
    tick();
    for (int i = 0; i < 8; i++) begin
      chk("t2_stb_hi", m_if.stb, 1);
      chk("t2_no_err", s_if.err, 0);
      tick();
    end
    chk("t2_stb_lo", m_if.stb, 0);
    chk("t2_err", s_if.err, 1);
    chk("t2_ack", s_if.ack, 0);
    chk("t2_tmo", timeout, 1);
    chk("t2_tcnt", tcount, 1);
    chk("t2_dat", s_if.dat_r, 0);
    host_drop();
    tick();
    chk("t2_err_once", s_if.err, 0);
    chk("t2_tmo_once", timeout, 0);
    tick();

    // 3: ack on the final wait cycle beats the timeout
    m_if.dat_r = 32'h55AA55AA;
    host_req(1'b0, 16'h0044, 32'h0, 4'hF);
    tick();
    for (int i = 0; i < 7; i++) tick();
    chk("t3_stb_last", m_if.stb, 1);
    m_if.ack = 1'b1;
    tick();
    m_if.ack = 1'b0;
    chk("t3_ack", s_if.ack, 1);
    chk("t3_dat", s_if.dat_r, 32'h55AA55AA);
    chk("t3_err", s_if.err, 0);
    chk("t3_tmo", timeout, 0);
    chk("t3_tcnt", tcount, 1);
    host_drop();
    tick();
    chk("t3_dat_clr", s_if.dat_r, 0);
    chk("t3_ack_once", s_if.ack, 0);

    // 4: host abort in REQ, then stray ack ignored, then a 2-cycle transaction
    host_req(1'b0, 16'h0100, 32'h0, 4'hF);
    tick();
    chk("t4_cyc1", m_if.cyc, 1);
    tick();
    chk("t4_cyc2", m_if.cyc, 1);
    host_drop();
    tick();
    chk("t4_cyc_off", m_if.cyc, 0);
    chk("t4_no_ack", s_if.ack, 0);
    chk("t4_no_err", s_if.err, 0);
    m_if.ack = 1'b1;
    tick();
    chk("t4_stray_ack", s_if.ack, 0);
    chk("t4_idle_cyc", m_if.cyc, 0);
    host_req(1'b1, 16'h0200, 32'hA5A5_0001, 4'h3);
    tick();
    chk("t4_stb", m_if.stb, 1);
    chk("t4_adr", m_if.adr, 16'h0200);
    chk("t4_sel", m_if.sel, 4'h3);
    tick();
    chk("t4_ack_min", s_if.ack, 1);
    m_if.ack = 1'b0;
    host_drop();
    tick();

    // 5: simultaneous ack+err gives err; back-to-back read follows
    host_req(1'b0, 16'h0300, 32'h0, 4'hF);
    tick();
    m_if.ack = 1'b1;
    m_if.err = 1'b1;
    tick();
    m_if.ack = 1'b0;
    m_if.err = 1'b0;
    chk("t5_err", s_if.err, 1);
    chk("t5_ack", s_if.ack, 0);
    chk("t5_tcnt", tcount, 1);
    host_req(1'b0, 16'h0304, 32'h0, 4'hF);
    tick();
    chk("t5_resp_stb", m_if.stb, 0);
    chk("t5_err_once", s_if.err, 0);
    tick();
    chk("t5_b2b_stb", m_if.stb, 1);
    chk("t5_b2b_adr", m_if.adr, 16'h0304);
    m_if.dat_r = 32'h12345678;
    m_if.ack = 1'b1;
    tick();
    m_if.ack = 1'b0;
    chk("t5_b2b_ack", s_if.ack, 1);
    chk("t5_b2b_dat", s_if.dat_r, 32'h12345678);
    host_drop();
    tick();

    // 6a: asynchronous reset in REQ
    host_req(1'b1, 16'h0400, 32'hDEADBEEF, 4'hF);
    tick();
    chk("t6_cyc_pre", m_if.cyc, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_cyc", m_if.cyc, 0);
    chk("t6_rst_stb", m_if.stb, 0);
    chk("t6_rst_adr", m_if.adr, 0);
    chk("t6_rst_dat", m_if.dat_w, 0);
    chk("t6_rst_ack", s_if.ack, 0);
    chk("t6_rst_err", s_if.err, 0);
    chk("t6_rst_tcnt", tcount, 0);
    host_drop();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("t6_post_ack", s_if.ack, 0);
    chk("t6_post_err", s_if.err, 0);
    chk("t6_post_cyc", m_if.cyc, 0);

    // 6b: 300 timeouts saturate the 8-bit counter
    for (int i = 0; i < 300; i++) begin
      int k;
      host_req(1'b0, 16'h0500, 32'h0, 4'hF);
      tick();
      k = 0;
      while (!s_if.err && k < 20) begin
        tick();
        k++;
      end
      chk("t6_tmo_seen", s_if.err, 1);
      chk("t6_tcnt_step", tcount, (i + 1 > 255) ? 255 : i + 1);
      host_drop();
      tick();
    end
    chk("t6_tcnt_sat", tcount, 8'hFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
